// File: rtl/trng_pkg.sv
// Shared constants and pair-state type for the TRNG whitening path.
// Imported by trng_whitener and byte_fifo.
package trng_pkg;
    localparam int TRNG_WIDTH = 13;
    localparam int BYTE_W     = 8;
    localparam int LED_W      = 5;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } pair_state_e;
endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO with registered storage; head entry is visible while not empty.
// Latency: a push at edge E is visible at the head after E when the FIFO was empty.
// Backpressure: push when full is accepted only if a pop happens on the same edge, else dropped.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_dat
);
    import trng_pkg::*;

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic         push_ok;
    logic         pop_ok;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop);
    assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_dat;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: rtl/trng_whitener.sv
// Folds LFSR words to parity, von Neumann debiases pairs, packs bits LSB-first into bytes.
// Latency: byte visible one cycle after its 8th extracted bit (FIFO empty).
// Backpressure: valid/ready output; bytes arriving to a full FIFO without a pop are dropped, overflow sticks.
module trng_whitener #(
    parameter int WIDTH      = trng_pkg::TRNG_WIDTH,
    parameter int FIFO_DEPTH = trng_pkg::FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [WIDTH-1:0]              rnd,
    input  logic                          rnd_valid,
    output logic [trng_pkg::BYTE_W-1:0]   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    output logic [trng_pkg::LED_W-1:0]    led
);
    import trng_pkg::*;

    pair_state_e       state_q, state_d;
    logic              held_q, held_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              overflow_q, overflow_d;
    logic [LED_W-1:0]  led_q, led_d;

    logic              p;
    logic              ext_vld;
    logic              byte_done;
    logic [BYTE_W-1:0] byte_dat;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;

    assign p         = ^rnd;
    assign pop       = out_valid && out_ready;
    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;
    assign led       = led_q;

    always_comb begin
        state_d    = state_q;
        held_d     = held_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        overflow_d = overflow_q;
        led_d      = led_q;
        ext_vld    = 1'b0;

        if (rnd_valid) begin
            case (state_q)
                EMPTY: begin
                    held_d  = p;
                    state_d = HELD;
                end
                HELD: begin
                    ext_vld = (p != held_q);
                    state_d = EMPTY;
                end
                default: state_d = EMPTY;
            endcase
        end

        // The extracted bit is the first of the pair, shifted in at the MSB.
        byte_dat  = {held_q, shreg_q[BYTE_W-1:1]};
        byte_done = ext_vld && (bit_cnt_q == 3'd7);
        if (ext_vld) begin
            shreg_d   = byte_dat;
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        if (byte_done && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
        if (pop) begin
            led_d = out_data[LED_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            held_q     <= 1'b0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            overflow_q <= 1'b0;
            led_q      <= '0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            overflow_q <= overflow_d;
            led_q      <= led_d;
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (BYTE_W)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (byte_done),
        .push_dat (byte_dat),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_dat (out_data)
    );
endmodule
